dmem_arbiter: RTL and testbench

// - Shares the single-port data memory (1024 x 32, sync write, comb read) between
//   two requesters: M0 = CPU MEM stage, M1 = debug/program-loader port.
// - One access per cycle; same-cycle grant; registered read response one cycle later.
// - Produces the CPU stall (m0_req & ~m0_gnt) consumed by the hazard unit.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of the single-port data memory
//
// Purpose:
//   Shares one 1024 x 32 data memory (sync write, comb read) between M0 (CPU MEM
//   stage) and M1 (debug / program-loader port). One access per cycle, grant given
//   in the same cycle, read response registered and presented the following cycle.
//   Raises cpu_stall whenever M0 is requesting but not granted.
//
// Configuration:
//   DMEM_ARB_RR_EN  defined   -> round-robin on conflict (side not in last_gnt wins)
//                   undefined -> fixed M0 priority, M1 forced a grant after
//                                STARVE_LIMIT consecutive losses
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_req/we/addr/wdata      M0 request (level, held until granted)
//   m0_gnt                    M0 accepted this cycle (combinational)
//   m0_rvalid/m0_rdata        M0 read response (registered, cycle after grant)
//   m1_*                      same set for M1
//   err                       registered pulse: granted access was out of range
//   cpu_stall                 m0_req & ~m0_gnt
//   mem_we/mem_addr/mem_wd    memory drive from the granted side (0 when idle)
//   mem_rd                    memory combinational read data

module dmem_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 1024,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              err,
   output logic              cpu_stall,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

`ifdef DMEM_ARB_RR_EN
   // 0 = M0 was granted last, 1 = M1 was granted last
   logic last_gnt;
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt;
`endif

   logic              any_gnt;
   logic              sel_we;
   logic              sel_in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wd;
   logic [DATA_W-1:0] rd_resp;

   // Grant decision; nothing is granted while reset is held
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            if (last_gnt) m0_gnt = 1'b1;
            else          m1_gnt = 1'b1;
`else
            if (starve_cnt == LIMIT) m1_gnt = 1'b1;
            else                     m0_gnt = 1'b1;
`endif
         end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
         end
      end
   end

   // Memory-side mux from whichever side won
   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_wd   = '0;
      if (m1_gnt) begin
         sel_we   = m1_we;
         sel_addr = m1_addr;
         sel_wd   = m1_wdata;
      end else if (m0_gnt) begin
         sel_we   = m0_we;
         sel_addr = m0_addr;
         sel_wd   = m0_wdata;
      end
   end

   assign any_gnt      = m0_gnt | m1_gnt;
   assign sel_in_range = (sel_addr < DEPTH_A);
   assign mem_we       = any_gnt & sel_we & sel_in_range;
   assign mem_addr     = sel_addr;
   assign mem_wd       = sel_wd;
   assign cpu_stall    = m0_req & ~m0_gnt;

   // Out-of-range reads complete with zero data rather than whatever mem_rd shows
   assign rd_resp = sel_in_range ? mem_rd : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rvalid <= 1'b0;
         m1_rdata  <= '0;
         err       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_gnt  <= 1'b1;
`else
         starve_cnt <= '0;
`endif
      end else begin
         m0_rvalid <= m0_gnt & ~m0_we;
         m1_rvalid <= m1_gnt & ~m1_we;
         // rdata only moves on a granted read; otherwise the last response is held
         if (m0_gnt && !m0_we) m0_rdata <= rd_resp;
         if (m1_gnt && !m1_we) m1_rdata <= rd_resp;
         err <= any_gnt & ~sel_in_range;
`ifdef DMEM_ARB_RR_EN
         if (m0_gnt)      last_gnt <= 1'b0;
         else if (m1_gnt) last_gnt <= 1'b1;
`else
         if (!m1_req || m1_gnt)     starve_cnt <= '0;
         else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        err, cpu_stall, mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   logic [31:0] mem [0:1023];

   int vectors;
   int miscompares;

   dmem_arbiter #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .err(err), .cpu_stall(cpu_stall),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: sync write, comb read; out-of-range shows a poison value
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
   end
   assign mem_rd = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
   endtask

   initial begin
      logic prev_m0, prev_m1, exp_m1;
      vectors     = 0;
      miscompares = 0;

      // Reset held two cycles with both sides requesting
      rst = 1'b1;
      drive(1, 0, 32'd0, 32'd0, 1, 0, 32'd0, 32'd0);
      tick(); #2;
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      tick(); #2;
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_err", err, 0);
      chk("rst_cpu_stall", cpu_stall, 1);

      // M0 write 0x20 to addr 8
      tick(); rst = 1'b0;
      drive(1, 1, 32'd8, 32'h20, 0, 0, 32'd0, 32'd0); #2;
      chk("m0_wr_gnt", m0_gnt, 1);
      chk("m0_wr_mem_we", mem_we, 1);
      chk("m0_wr_mem_addr", mem_addr, 32'd8);
      chk("m0_wr_mem_wd", mem_wd, 32'h20);
      chk("m0_wr_stall", cpu_stall, 0);

      // M0 read addr 8
      tick(); drive(1, 0, 32'd8, 32'h0, 0, 0, 32'd0, 32'd0); #2;
      chk("m0_rd_gnt", m0_gnt, 1);
      chk("m0_wr_no_rvalid", m0_rvalid, 0);
      chk("m0_rd_mem_we", mem_we, 0);

      tick(); drive(0, 0, 32'd8, 32'h0, 0, 0, 32'd0, 32'd0); #2;
      chk("m0_rd_rvalid", m0_rvalid, 1);
      chk("m0_rd_rdata", m0_rdata, 32'h20);
      chk("idle_gnt", m0_gnt, 0);
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("idle_mem_we", mem_we, 0);

      tick(); #2;
      chk("m0_rvalid_drop", m0_rvalid, 0);
      chk("m0_rdata_held", m0_rdata, 32'h20);

      // M1 write 0x1234 to addr 9, then back-to-back reads 9 and 8
      tick(); drive(0, 0, 32'd0, 32'd0, 1, 1, 32'd9, 32'h1234); #2;
      chk("m1_wr_gnt", m1_gnt, 1);
      chk("m1_wr_mem_we", mem_we, 1);
      chk("m1_wr_mem_wd", mem_wd, 32'h1234);
      tick(); drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd9, 32'h0); #2;
      chk("m1_rd9_gnt", m1_gnt, 1);
      tick(); drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd8, 32'h0); #2;
      chk("b2b_m1_gnt", m1_gnt, 1);
      chk("b2b_m1_rvalid", m1_rvalid, 1);
      chk("b2b_m1_rdata9", m1_rdata, 32'h1234);
      tick(); drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'h0); #2;
      chk("b2b2_m1_rvalid", m1_rvalid, 1);
      chk("b2b2_m1_rdata8", m1_rdata, 32'h20);
      chk("b2b_m0_rvalid", m0_rvalid, 0);

      // Out of range: M1 write 1024, then read 2000
      tick(); drive(0, 0, 32'd0, 32'd0, 1, 1, 32'd1024, 32'h55); #2;
      chk("oor_wr_gnt", m1_gnt, 1);
      chk("oor_wr_mem_we", mem_we, 0);
      chk("oor_pre_err", err, 0);
      tick(); drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd2000, 32'h0); #2;
      chk("oor_wr_err", err, 1);
      chk("oor_wr_no_rvalid", m1_rvalid, 0);
      chk("oor_rd_gnt", m1_gnt, 1);
      tick(); drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'h0); #2;
      chk("oor_rd_rvalid", m1_rvalid, 1);
      chk("oor_rd_rdata", m1_rdata, 32'h0);
      chk("oor_rd_err", err, 1);
      tick(); #2;
      chk("oor_err_pulse", err, 0);

      // Sustained conflict: M0 reads 8, M1 reads 9
      prev_m0 = 1'b0;
      prev_m1 = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         tick(); drive(1, 0, 32'd8, 32'h0, 1, 0, 32'd9, 32'h0); #2;
         exp_m1 = RR ? (i % 2 == 0) : (i % 5 == 0);
         chk($sformatf("conf%0d_m0_gnt", i), m0_gnt, !exp_m1);
         chk($sformatf("conf%0d_m1_gnt", i), m1_gnt, exp_m1);
         chk($sformatf("conf%0d_stall", i), cpu_stall, exp_m1);
         chk($sformatf("conf%0d_m0_rvalid", i), m0_rvalid, prev_m0);
         chk($sformatf("conf%0d_m1_rvalid", i), m1_rvalid, prev_m1);
         if (prev_m0) chk($sformatf("conf%0d_m0_rdata", i), m0_rdata, 32'h20);
         if (prev_m1) chk($sformatf("conf%0d_m1_rdata", i), m1_rdata, 32'h1234);
         prev_m0 = !exp_m1;
         prev_m1 = exp_m1;
      end

      // Reset in the middle of traffic with an M0 read to addr 4 pending
      tick(); rst = 1'b1;
      drive(1, 0, 32'd4, 32'h0, 1, 0, 32'd9, 32'h0); #2;
      chk("mid_rst_m0_gnt", m0_gnt, 0);
      chk("mid_rst_m1_gnt", m1_gnt, 0);
      for (int j = 1; j <= 5; j++) begin
         tick(); rst = 1'b0; #2;
         exp_m1 = RR ? (j % 2 == 0) : (j % 5 == 0);
         if (j == 1) begin
            chk("post_rst_m0_rvalid", m0_rvalid, 0);
            chk("post_rst_m1_rvalid", m1_rvalid, 0);
            chk("post_rst_m0_rdata", m0_rdata, 32'h0);
         end
         chk($sformatf("post%0d_m0_gnt", j), m0_gnt, !exp_m1);
         chk($sformatf("post%0d_m1_gnt", j), m1_gnt, exp_m1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
